pe_array_sequencer: RTL and testbench

//  Command sequencer between the host/instruction source and the PE array's broadcast control inputs.

---
 rtl/pe_array_pkg.sv | 30 +++
 rtl/seq_watchdog.sv | 31 +++
 rtl/pe_array_sequencer.sv | 123 ++++++++++++
 tb/tb_pe_array_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pe_array_pkg.sv
// Shared opcodes, direction codes, state encoding and instruction record for
// the PE array command sequencer.
package pe_array_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHIFT = 3'd2;
  localparam logic [2:0] OP_MAC   = 3'd3;
  localparam logic [2:0] OP_READ  = 3'd4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK,
    ST_ERROR
  } seq_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] dir;
    logic       img;
  } instr_t;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter for the WAIT state; tc is high during the TIMEOUT-th enabled
// cycle since the last clear.
module seq_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TC_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc = en && (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                         cnt_d = '0;
    else if (en && (cnt_q < TC_VAL)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// Single-entry command sequencer: issues one host instruction REPEAT+1 times to
// the PE array, handshaking on the array's AND-reduced ready.
module pe_array_sequencer
  import pe_array_pkg::*;
#(
  parameter int REPEAT_W = 4,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [2:0]          instr_opcode,
  input  logic [1:0]          instr_dir,
  input  logic                instr_image,
  input  logic [REPEAT_W-1:0] instr_repeat,
  input  logic                array_ready,
  output logic [2:0]          command_to_execute,
  output logic [1:0]          shift_direction,
  output logic                image_to_shift,
  output logic                array_ack,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic                err_clear,
  output logic [CNT_W-1:0]    op_count
);

  seq_state_e          state_q, state_d;
  instr_t              cur_q, cur_d;
  logic [REPEAT_W-1:0] rem_q, rem_d;
  logic [2:0]          cmd_q, cmd_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wd_tc;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (state_q != ST_WAIT),
    .en    (state_q == ST_WAIT),
    .tc    (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: if (instr_valid && ready_q) begin
        cur_d   = '{op: instr_opcode, dir: instr_dir, img: instr_image};
        rem_d   = instr_repeat;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      // ready beats the watchdog when both land in the same cycle
      ST_WAIT: begin
        if (array_ready) state_d = ST_ACK;
        else if (wd_tc)  state_d = ST_ERROR;
      end
      ST_ACK: begin
        if (rem_q == '0) state_d = ST_IDLE;
        else begin
          rem_d   = rem_q - REPEAT_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ERROR: if (err_clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops aligned with it
    cmd_d   = ((state_d == ST_ISSUE) || (state_d == ST_WAIT)) ? cur_d.op : OP_NOP;
    ack_d   = (state_d == ST_ACK);
    done_d  = (state_d == ST_ACK) && (rem_d == '0);
    busy_d  = (state_d != ST_IDLE);
    err_d   = (state_d == ST_ERROR);
    ready_d = (state_d == ST_IDLE);
    cnt_d   = cnt_q + CNT_W'(ack_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      cmd_q   <= OP_NOP;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready        = ready_q;
  assign command_to_execute = cmd_q;
  assign shift_direction    = cur_q.dir;
  assign image_to_shift     = cur_q.img;
  assign array_ack          = ack_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign op_count           = cnt_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed plus randomized instruction bench for pe_array_sequencer, with a
// transaction-level timing model of each execution.
module tb_pe_array_sequencer;

  localparam int RW = 4;
  localparam int TO = 12;
  localparam int CW = 5;

  logic          CLK = 0, RST_N = 0;
  logic          instr_valid = 0, instr_ready;
  logic [2:0]    instr_opcode = 0;
  logic [1:0]    instr_dir = 0;
  logic          instr_image = 0;
  logic [RW-1:0] instr_repeat = 0;
  logic          array_ready = 0, err_clear = 0;
  logic [2:0]    cmd_o;
  logic [1:0]    dir_o;
  logic          img_o, ack_o, busy_o, done_o, err_o;
  logic [CW-1:0] cnt_o;

  int checks = 0, errors = 0;
  int exp_cnt = 0, total_ops = 0;

  pe_array_sequencer #(.REPEAT_W(RW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_dir(instr_dir),
    .instr_image(instr_image), .instr_repeat(instr_repeat),
    .array_ready(array_ready),
    .command_to_execute(cmd_o), .shift_direction(dir_o), .image_to_shift(img_o),
    .array_ack(ack_o), .busy(busy_o), .done(done_o), .err(err_o),
    .err_clear(err_clear), .op_count(cnt_o)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"}, 32'(cmd_o), 0);
    chk({tag, "_dir"}, 32'(dir_o), 0);
    chk({tag, "_img"}, 32'(img_o), 0);
    chk({tag, "_ack"}, 32'(ack_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_cnt"}, 32'(cnt_o), 0);
  endtask

  // One instruction: rep+1 executions, each waiting d WAIT cycles (ready is
  // raised in the d-th). d > TO means the array never answers.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] dir, input logic img,
                           input logic [RW-1:0] rep, input int fixed_d, input bit hold_valid);
    int d;
    chk("idle_ready", 32'(instr_ready), 1);
    instr_valid = 1; instr_opcode = op; instr_dir = dir; instr_image = img;
    instr_repeat = rep; array_ready = 1'($urandom);
    for (int e = 0; e <= int'(rep); e++) begin
      step();
      instr_valid = hold_valid; instr_opcode = 3'($urandom); instr_dir = 2'($urandom);
      instr_image = 1'($urandom); instr_repeat = RW'($urandom);
      chk("issue_cmd", 32'(cmd_o), 32'(op));
      chk("issue_dir", 32'(dir_o), 32'(dir));
      chk("issue_img", 32'(img_o), 32'(img));
      chk("issue_ready", 32'(instr_ready), 0);
      chk("issue_ack", 32'(ack_o), 0);
      chk("issue_busy", 32'(busy_o), 1);
      array_ready = 1'($urandom);
      d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, TO));
      for (int w = 1; w <= d && w <= TO; w++) begin
        step();
        chk("wait_cmd", 32'(cmd_o), 32'(op));
        chk("wait_ack", 32'(ack_o), 0);
        chk("wait_err", 32'(err_o), 0);
        array_ready = (w == d);
        err_clear = 1'($urandom);
      end
      step();
      if (d > TO) begin
        err_clear = 0; array_ready = 0;
        chk("err_set", 32'(err_o), 1);
        chk("err_ack", 32'(ack_o), 0);
        chk("err_cmd", 32'(cmd_o), 0);
        chk("err_busy", 32'(busy_o), 1);
        chk("err_ready", 32'(instr_ready), 0);
        chk("err_cnt", 32'(cnt_o), 32'(exp_cnt));
        repeat (3) begin
          array_ready = 1'($urandom);
          step();
        end
        chk("err_sticky", 32'(err_o), 1);
        err_clear = 1;
        step();
        err_clear = 0;
        chk("errclr_err", 32'(err_o), 0);
        chk("errclr_ready", 32'(instr_ready), 1);
        chk("errclr_busy", 32'(busy_o), 0);
        return;
      end
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      total_ops++;
      chk("ack_pulse", 32'(ack_o), 1);
      chk("ack_cmd", 32'(cmd_o), 0);
      chk("ack_done", 32'(done_o), 32'(e == int'(rep)));
      chk("ack_cnt", 32'(cnt_o), 32'(exp_cnt));
      chk("ack_dir", 32'(dir_o), 32'(dir));
      chk("ack_err", 32'(err_o), 0);
      array_ready = 1'($urandom);
    end
    step();
    err_clear = 0;
    chk("end_ready", 32'(instr_ready), 1);
    chk("end_busy", 32'(busy_o), 0);
    chk("end_ack", 32'(ack_o), 0);
    chk("end_done", 32'(done_o), 0);
    chk("end_cmd", 32'(cmd_o), 0);
  endtask

  initial begin
    int fd;
    #1;
    chk_all_zero("rst");
    chk("rst_ready", 32'(instr_ready), 0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1;
    step();
    chk("rel_ready", 32'(instr_ready), 1);

    run_instr(3'd2, 2'd2, 1'b0, 4'd3, 1, 0);            // 4 back-to-back shifts
    chk("shift_total", 32'(cnt_o), 4);
    run_instr(3'd3, 2'd1, 1'b1, 4'd0, 10, 0);           // slow array
    run_instr(3'd1, 2'd3, 1'b1, 4'd0, TO, 0);           // ready on the timeout cycle
    run_instr(3'd4, 2'd0, 1'b0, 4'd2, TO + 1, 0);       // array never ready
    run_instr(3'd1, 2'd1, 1'b0, 4'd0, 1, 1);            // valid held high across ops
    run_instr(3'd2, 2'd3, 1'b1, 4'd1, 1, 0);
    run_instr(3'd0, 2'd0, 1'b0, 4'd0, 1, 0);            // NOP still counted

    // Reset in the middle of WAIT
    instr_valid = 1; instr_opcode = 3'd3; instr_dir = 2'd2; instr_image = 1;
    instr_repeat = 4'd2; array_ready = 0;
    step();
    instr_valid = 0;
    repeat (2) step();
    chk("mid_cmd", 32'(cmd_o), 3);
    #2 RST_N = 0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_ready", 32'(instr_ready), 0);
    exp_cnt = 0;
    @(posedge CLK);
    #3 RST_N = 1;
    step();
    chk("midrel_ready", 32'(instr_ready), 1);
    chk("midrel_ack", 32'(ack_o), 0);

    // Random traffic, long enough to wrap the op counter at least once
    for (int i = 0; i < 60 && total_ops < 50; i++) begin
      case ($urandom_range(0, 7))
        0:       fd = TO + 1;
        1:       fd = 1;
        2:       fd = TO;
        default: fd = 0;
      endcase
      run_instr(3'($urandom_range(0, 4)), 2'($urandom), 1'($urandom),
                RW'($urandom_range(0, 3)), fd, 1'($urandom));
    end
    chk("wrapped", 32'(total_ops >= 32), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
